jacobian_to_affine: RTL and testbench

Converts a secp256k1 point from Jacobian (X, Y, Z) to affine (x, y) = (X/Z², Y/Z³ mod P). It is the consumer end of the point-arithmetic path: point_double and point-add produce Jacobian results, and this block normalises them for output, comparison or serialisation. Z⁻¹ is computed by Fermat inversion (Z^(P−2)) using one shared mod_mul instance, then four further multiplies.

---
 rtl/ecc_pkg.sv | 26 ++
 rtl/mod_mul.sv | 64 ++++++
 rtl/jacobian_to_affine.sv | 230 +++++++++++++++++++++++
 tb/tb_jacobian_to_affine.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared secp256k1 constants and the jacobian_to_affine state encoding.
`default_nettype none

package ecc_pkg;

  localparam logic [255:0] SECP_P  =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] SECP_GX =
    256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
  localparam logic [255:0] SECP_GY =
    256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;

  typedef enum logic [2:0] {
    J2A_IDLE    = 3'd0,
    J2A_INV_SQ  = 3'd1,
    J2A_INV_MUL = 3'd2,
    J2A_ZI2     = 3'd3,
    J2A_XMUL    = 3'd4,
    J2A_ZI3     = 3'd5,
    J2A_YMUL    = 3'd6,
    J2A_DONE    = 3'd7
  } j2a_state_e;

endpackage

`default_nettype wire

// File: rtl/mod_mul.sv
// Two-stage modular multiplier (latency 2) for pseudo-Mersenne primes P = 2^256 - C,
// with P > 2^255 and C < 2^64; reduction folds the high half twice, then one final subtract.
`default_nettype none

module mod_mul
  import ecc_pkg::*;
#(
  parameter logic [255:0] P = SECP_P
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [255:0] a_i,
  input  logic [255:0] b_i,
  output logic [255:0] result_o,
  output logic         done_o
);

  localparam logic [255:0] C_FULL = ~P + 256'd1;
  localparam logic [63:0]  C      = C_FULL[63:0];

  logic [511:0] prod_q;
  logic         valid_q;
  logic [255:0] result_q;
  logic         done_q;

  logic [511:0] w_prod;
  logic [319:0] w_fold1;
  logic [320:0] w_r1;
  logic [128:0] w_fold2;
  logic [256:0] w_r2;
  logic [255:0] w_r3;
  logic [255:0] w_red;

  assign w_prod  = {256'd0, a_i} * {256'd0, b_i};

  // 2^256 == C (mod P): fold hi*C into lo, twice, then absorb the last carry bit.
  assign w_fold1 = {64'd0, prod_q[511:256]} * {256'd0, C};
  assign w_r1    = {65'd0, prod_q[255:0]} + {1'b0, w_fold1};
  assign w_fold2 = {64'd0, w_r1[320:256]} * {65'd0, C};
  assign w_r2    = {1'b0, w_r1[255:0]} + {128'd0, w_fold2};
  assign w_r3    = w_r2[255:0] + (w_r2[256] ? {192'd0, C} : 256'd0);
  assign w_red   = (w_r3 >= P) ? (w_r3 - P) : w_r3;

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q   <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      valid_q <= start_i;
      done_q  <= valid_q;
      if (start_i) prod_q <= w_prod;
      if (valid_q) result_q <= w_red;
    end
  end

  assign result_o = result_q;
  assign done_o   = done_q;

endmodule

`default_nettype wire

// File: rtl/jacobian_to_affine.sv
// Jacobian -> affine for secp256k1 via Fermat inversion on one shared mod_mul.
// Define JAC2AFF_CONST_TIME_EN to run the inversion multiply on every exponent bit.
`default_nettype none

module jacobian_to_affine
  import ecc_pkg::*;
#(
  parameter logic [255:0] P = SECP_P
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] X,
  input  logic [255:0] Y,
  input  logic [255:0] Z,
  output logic [255:0] x_out,
  output logic [255:0] y_out,
  output logic         inf,
  output logic         busy,
  output logic         done
);

  localparam logic [255:0] E = P - 256'd2;

  j2a_state_e   state_q, state_d;
  logic [7:0]   idx_q, idx_d;
  logic [255:0] acc_q, acc_d;
  logic [255:0] t_q, t_d;
  logic [255:0] x_cap_q, x_cap_d;
  logic [255:0] y_cap_q, y_cap_d;
  logic [255:0] z_cap_q, z_cap_d;
  logic [255:0] x_out_q, x_out_d;
  logic [255:0] y_out_q, y_out_d;
  logic         inf_q, inf_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         start_mul_q, start_mul_d;

  logic [255:0] w_opa, w_opb;
  logic [255:0] w_mul_result;
  logic         w_mul_done;
  logic         w_take_mul;

  mod_mul #(
    .P (P)
  ) u_mod_mul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_mul_q),
    .a_i      (w_opa),
    .b_i      (w_opb),
    .result_o (w_mul_result),
    .done_o   (w_mul_done)
  );

`ifdef JAC2AFF_CONST_TIME_EN
  assign w_take_mul = 1'b1;
`else
  assign w_take_mul = E[idx_q];
`endif

  // Operands follow the state; they are sampled by mod_mul only while start_mul_q is high.
  always_comb begin
    w_opa = acc_q;
    w_opb = acc_q;
    case (state_q)
      J2A_INV_MUL: w_opb = z_cap_q;
      J2A_XMUL: begin
        w_opa = x_cap_q;
        w_opb = t_q;
      end
      J2A_ZI3: begin
        w_opa = t_q;
        w_opb = acc_q;
      end
      J2A_YMUL: begin
        w_opa = y_cap_q;
        w_opb = t_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    t_d         = t_q;
    x_cap_d     = x_cap_q;
    y_cap_d     = y_cap_q;
    z_cap_d     = z_cap_q;
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    inf_d       = inf_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    start_mul_d = 1'b0;

    case (state_q)
      J2A_IDLE: begin
        if (start) begin
          if (Z == '0) begin
            x_out_d = '0;
            y_out_d = '0;
            inf_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            x_cap_d     = X;
            y_cap_d     = Y;
            z_cap_d     = Z;
            acc_d       = Z;
            idx_d       = 8'd254;
            inf_d       = 1'b0;
            busy_d      = 1'b1;
            start_mul_d = 1'b1;
            state_d     = J2A_INV_SQ;
          end
        end
      end

      J2A_INV_SQ: begin
        if (w_mul_done) begin
          acc_d       = w_mul_result;
          start_mul_d = 1'b1;
          if (w_take_mul) begin
            state_d = J2A_INV_MUL;
          end else if (idx_q == 8'd0) begin
            state_d = J2A_ZI2;
          end else begin
            idx_d = idx_q - 8'd1;
          end
        end
      end

      J2A_INV_MUL: begin
        if (w_mul_done) begin
          // Zero exponent bits only reach here in the constant-time build; the product is dropped.
          if (E[idx_q]) acc_d = w_mul_result;
          start_mul_d = 1'b1;
          if (idx_q == 8'd0) begin
            state_d = J2A_ZI2;
          end else begin
            idx_d   = idx_q - 8'd1;
            state_d = J2A_INV_SQ;
          end
        end
      end

      J2A_ZI2: begin
        if (w_mul_done) begin
          t_d         = w_mul_result;
          start_mul_d = 1'b1;
          state_d     = J2A_XMUL;
        end
      end

      J2A_XMUL: begin
        if (w_mul_done) begin
          x_out_d     = w_mul_result;
          start_mul_d = 1'b1;
          state_d     = J2A_ZI3;
        end
      end

      J2A_ZI3: begin
        if (w_mul_done) begin
          t_d         = w_mul_result;
          start_mul_d = 1'b1;
          state_d     = J2A_YMUL;
        end
      end

      J2A_YMUL: begin
        if (w_mul_done) begin
          y_out_d = w_mul_result;
          state_d = J2A_DONE;
        end
      end

      J2A_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = J2A_IDLE;
      end

      default: state_d = J2A_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= J2A_IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      t_q         <= '0;
      x_cap_q     <= '0;
      y_cap_q     <= '0;
      z_cap_q     <= '0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      inf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_mul_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      t_q         <= t_d;
      x_cap_q     <= x_cap_d;
      y_cap_q     <= y_cap_d;
      z_cap_q     <= z_cap_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      inf_q       <= inf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      start_mul_q <= start_mul_d;
    end
  end

  assign x_out = x_out_q;
  assign y_out = y_out_q;
  assign inf   = inf_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_jacobian_to_affine.sv
// Self-checking bench for jacobian_to_affine: vector table, scoreboard queue, reset/abort sequences.
`default_nettype none

module tb_jacobian_to_affine;
  import ecc_pkg::*;

  localparam logic [255:0] P   = SECP_P;
  localparam logic [255:0] X2G =
    256'hC6047F94_41ED7D6D_3045406E_95C07CD8_5C778E4B_8CEF3CA7_ABAC09B9_5C709EE5;
  localparam int L = 2;
`ifdef JAC2AFF_CONST_TIME_EN
  localparam int N_OPS = 514;
`else
  localparam int N_OPS = 507;
`endif
  localparam int LAT   = N_OPS * (L + 1) + 2;
  localparam int BOUND = LAT + 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] X, Y, Z;
  logic [255:0] x_out, y_out;
  logic         inf, busy, done;

  always #5 clk = ~clk;

  jacobian_to_affine dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .X     (X),
    .Y     (Y),
    .Z     (Z),
    .x_out (x_out),
    .y_out (y_out),
    .inf   (inf),
    .busy  (busy),
    .done  (done)
  );

  typedef struct {
    logic [255:0] x, y, z;
    logic [255:0] ex, ey;
    logic         einf;
  } vec_t;

  typedef struct {
    logic [255:0] ex, ey;
    logic         einf;
    int           elat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;

  // Reference field arithmetic: bitwise double-and-add multiply, square-and-multiply inverse.
  function automatic logic [255:0] addm(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[255:0];
  endfunction

  function automatic logic [255:0] subm(input logic [255:0] a, input logic [255:0] b);
    if (a >= b) return a - b;
    return a + (P - b);
  endfunction

  function automatic logic [255:0] mulm(input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r;
    r = '0;
    for (int i = 255; i >= 0; i--) begin
      r = addm(r, r);
      if (b[i]) r = addm(r, a);
    end
    return r;
  endfunction

  function automatic logic [255:0] invm(input logic [255:0] a);
    logic [255:0] r;
    logic [255:0] e;
    r = 256'd1;
    e = P - 256'd2;
    for (int i = 255; i >= 0; i--) begin
      r = mulm(r, r);
      if (e[i]) r = mulm(r, a);
    end
    return r;
  endfunction

  function automatic vec_t model_vec(input logic [255:0] x, input logic [255:0] y,
                                     input logic [255:0] z);
    vec_t v;
    logic [255:0] zi, zi2;
    v.x = x; v.y = y; v.z = z;
    zi   = invm(z);
    zi2  = mulm(zi, zi);
    v.ex = mulm(x, zi2);
    v.ey = mulm(y, mulm(zi2, zi));
    v.einf = 1'b0;
    return v;
  endfunction

  function automatic logic [255:0] rnd();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    r[255] = 1'b0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, {255'd0, busy}, 256'd0);
    chk({tag, "_done"}, {255'd0, done}, 256'd0);
    chk({tag, "_x"}, x_out, 256'd0);
    chk({tag, "_y"}, y_out, 256'd0);
    chk({tag, "_inf"}, {255'd0, inf}, 256'd0);
  endtask

  // poke_at: pulse a conflicting start at that cycle; rst_at: abort the op at that cycle.
  task automatic run_op(input vec_t v, input string tag, input int poke_at, input int rst_at);
    exp_t e;
    int   cyc;
    int   extra;
    logic saw_busy;
    @(negedge clk);
    X = v.x; Y = v.y; Z = v.z; start = 1'b1;
    e.ex = v.ex; e.ey = v.ey; e.einf = v.einf;
    e.elat = (v.z == '0) ? 1 : LAT;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    X = ~v.x; Y = ~v.y; Z = 256'd5;
    cyc = 1;
    saw_busy = 1'b0;
    while (!done && cyc < BOUND) begin
      if (busy) saw_busy = 1'b1;
      start = (cyc == poke_at);
      if (cyc == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_zero_outputs({tag, "_abort"});
        e = sb.pop_front();
        return;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    e = sb.pop_front();
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no done after %0d cycles, required %0d", tag, cyc, e.elat);
      return;
    end
    chk({tag, "_x"}, x_out, e.ex);
    chk({tag, "_y"}, y_out, e.ey);
    chk({tag, "_inf"}, {255'd0, inf}, {255'd0, e.einf});
    chk_int({tag, "_latency"}, cyc, e.elat);
    chk_int({tag, "_busy_at_done"}, int'(busy), 0);
    chk_int({tag, "_busy_seen"}, int'(saw_busy), (v.z != '0) ? 1 : 0);
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk_int({tag, "_done_once"}, extra, 0);
  endtask

  initial begin
    logic [255:0] yy, s, m, x3, y3, z3;
    vec_t vp;
    rst = 1'b1; start = 1'b0; X = '0; Y = '0; Z = '0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_zero_outputs("post_reset");

    vecs[0] = '{x: SECP_GX, y: SECP_GY, z: 256'd1, ex: SECP_GX, ey: SECP_GY, einf: 1'b0};
    vecs[1] = '{x: mulm(SECP_GX, 256'd4), y: mulm(SECP_GY, 256'd8), z: 256'd2,
                ex: SECP_GX, ey: SECP_GY, einf: 1'b0};
    // Jacobian doubling of G (a = 0): S=4XY^2, M=3X^2, X3=M^2-2S, Y3=M(S-X3)-8Y^4, Z3=2Y.
    yy = mulm(SECP_GY, SECP_GY);
    s  = mulm(256'd4, mulm(SECP_GX, yy));
    m  = mulm(256'd3, mulm(SECP_GX, SECP_GX));
    x3 = subm(mulm(m, m), addm(s, s));
    y3 = subm(mulm(m, subm(s, x3)), mulm(256'd8, mulm(yy, yy)));
    z3 = addm(SECP_GY, SECP_GY);
    vecs[2] = model_vec(x3, y3, z3);
    vecs[2].ex = X2G;
    vecs[3] = '{x: rnd(), y: rnd(), z: 256'd0, ex: 256'd0, ey: 256'd0, einf: 1'b1};
    vecs[4] = model_vec(rnd(), rnd(), rnd());
    vecs[5].x = rnd(); vecs[5].y = rnd(); vecs[5].z = P - 256'd1;
    vecs[5].ex = vecs[5].x; vecs[5].ey = subm(256'd0, vecs[5].y); vecs[5].einf = 1'b0;
    vecs[6] = '{x: 256'd0, y: 256'd0, z: 256'd3, ex: 256'd0, ey: 256'd0, einf: 1'b0};
    vecs[7] = '{x: P - 256'd1, y: 256'd1, z: 256'd1, ex: P - 256'd1, ey: 256'd1, einf: 1'b0};

    for (int i = 0; i < 8; i++) run_op(vecs[i], $sformatf("vec%0d", i), 0, 0);

    run_op(vecs[1], "busy_start", 100, 0);
    vp = vecs[4];
    run_op(vp, "abort", 0, 300);
    run_op(vecs[2], "after_abort", 0, 0);
    run_op(vecs[3], "inf_again", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
